// File: rtl/eth_rx_fcs_check.sv
// MII receive FCS checker: strips preamble/SFD, checks CRC-32 and emits payload bytes with last/ok status.
// Optional ETH_RX_BAD_CNT_EN adds a saturating bad-frame counter output bad_cnt.
module eth_rx_fcs_check #(
  parameter logic [31:0] CRC_POLY    = 32'hEDB88320,
  parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_dv,
  input  logic [3:0] rxd,
  input  logic       rx_er,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_ok,
  output logic       frame_err
`ifdef ETH_RX_BAD_CNT_EN
  ,
  output logic [15:0] bad_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [3:0]  low_nib;
  logic        phase;
  logic [2:0]  count;
  logic [7:0]  byte_buf [5];

  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc       <= '1;
      low_nib   <= '0;
      phase     <= 1'b0;
      count     <= '0;
      for (int unsigned i = 0; i < 5; i++) byte_buf[i] <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_ok      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_ok      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_dv) state <= (rxd == 4'h5) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rxd == 4'hD) begin
            state <= DATA;
            phase <= 1'b0;
            crc   <= '1;
            count <= '0;
          end else if (rxd != 4'h5) begin
            state     <= DROP;
            frame_err <= 1'b1;
          end
        end
        DATA: begin
          if (!rx_dv) begin
            state <= IDLE;
            count <= '0;
            // With 5 buffered bytes the oldest is the last payload byte; the other 4 are the FCS.
            if (count == 3'd5 && !phase) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_ok    <= (crc == CRC_RESIDUE);
              m_data  <= byte_buf[0];
            end else begin
              frame_err <= 1'b1;
            end
          end else if (rx_er) begin
            state     <= DROP;
            count     <= '0;
            frame_err <= 1'b1;
          end else begin
            crc   <= crc_nibble(crc, rxd);
            phase <= ~phase;
            if (!phase) begin
              low_nib <= rxd;
            end else begin
              for (int unsigned i = 0; i < 4; i++) byte_buf[i] <= byte_buf[i+1];
              byte_buf[4] <= {rxd, low_nib};
              if (count == 3'd5) begin
                m_valid <= 1'b1;
                m_data  <= byte_buf[0];
              end else begin
                count <= count + 3'd1;
              end
            end
          end
        end
        DROP: begin
          if (!rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_RX_BAD_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_cnt <= '0;
    end else if (((m_valid && m_last && !m_ok) || frame_err) && bad_cnt != '1) begin
      bad_cnt <= bad_cnt + 16'd1;
    end
  end
`endif

endmodule
